// File: rtl/morse_message_sequencer.sv
// morse_message_sequencer: steps a latched message of 3-bit letter codes into the morse shift stage,
// one load strobe per letter, paced by a symbol divider matched to the shift stage.
module morse_message_sequencer #(
  parameter int TICK_DIV  = 25000000,
  parameter int MAX_LEN   = 8,
  parameter int SYM_BITS  = 12,
  parameter int GAP_TICKS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3*MAX_LEN-1:0] msg,
  input  logic [3:0]           msg_len,
  output logic [2:0]           select,
  output logic                 load_n,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           letter_idx,
  output logic                 sym_tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SYM_BITS + GAP_TICKS + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;
  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [SW-1:0]            scnt;
  logic [MAX_LEN-1:0][2:0]  msg_q;
  logic [3:0]               len_q, len_c;
  logic [2:0]               nidx;
  logic                     more;
  always_comb begin
    len_c    = msg_len > 4'(MAX_LEN) ? 4'(MAX_LEN) : msg_len;
    nidx     = letter_idx + 3'd1;
    more     = 4'(letter_idx) + 4'd1 < len_q;
    sym_tick = busy && cnt == CW'(TICK_DIV - 1);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      scnt       <= '0;
      msg_q      <= '0;
      len_q      <= '0;
      select     <= '0;
      load_n     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      letter_idx <= '0;
    end else begin
      cnt  <= (busy && !sym_tick) ? cnt + 1'b1 : '0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          msg_q      <= msg;
          len_q      <= len_c;
          letter_idx <= '0;
          if (len_c != 4'd0) begin
            state  <= S_LOAD;
            busy   <= 1'b1;
            select <= msg[2:0];
            load_n <= 1'b0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_LOAD: if (sym_tick) begin
          load_n <= 1'b1;
          scnt   <= '0;
          state  <= S_SEND;
        end
        S_SEND: if (sym_tick) begin
          scnt  <= scnt == SW'(SYM_BITS - 1) ? '0 : scnt + 1'b1;
          state <= scnt == SW'(SYM_BITS - 1) ? S_GAP : S_SEND;
        end
        S_GAP: if (sym_tick) begin
          if (scnt == SW'(GAP_TICKS - 1)) begin
            scnt <= '0;
            if (more) begin
              letter_idx <= nidx;
              select     <= msg_q[nidx];
              load_n     <= 1'b0;
              state      <= S_LOAD;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_message_sequencer.sv
// tb_morse_message_sequencer: directed scenarios with TICK_DIV=4, so one letter spans 64 cycles.
module tb_morse_message_sequencer;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [23:0] msg = '0;
  logic [3:0]  msg_len = '0;
  logic [2:0]  select, letter_idx;
  logic        load_n, busy, done, sym_tick;
  int          total = 0, bad = 0, cyc = 0, t0 = 0, nfall = 0, ndone = 0, dt = -1;
  int          ft[16];
  logic [2:0]  fs[16], fi[16];
  logic        prev_ln = 1'b1;
  bit          ok;
  always #5 clock = ~clock;
  morse_message_sequencer #(.TICK_DIV(4), .MAX_LEN(8), .SYM_BITS(12), .GAP_TICKS(3)) dut (
    .clock(clock), .reset(reset), .start(start), .msg(msg), .msg_len(msg_len),
    .select(select), .load_n(load_n), .busy(busy), .done(done),
    .letter_idx(letter_idx), .sym_tick(sym_tick)
  );
  // Advance to the next falling edge and log load_n falls and done pulses.
  task step();
    @(negedge clock);
    cyc++;
    if (prev_ln && !load_n && nfall < 16) begin
      ft[nfall] = cyc; fs[nfall] = select; fi[nfall] = letter_idx; nfall++;
    end
    if (done) begin
      if (ndone == 0) dt = cyc;
      ndone++;
    end
    prev_ln = load_n;
  endtask
  task clear_rec();
    nfall = 0; ndone = 0; dt = -1;
  endtask
  task send(input logic [23:0] m, input logic [3:0] l);
    start = 1'b1; msg = m; msg_len = l; t0 = cyc;
    step();
    start = 1'b0;
  endtask
  task wait_done(input int budget, output bit got);
    for (int i = 0; i < budget && ndone == 0; i++) step();
    got = ndone > 0;
  endtask
  task test_reset();
    reset = 1'b1;
    step(); step();
    total++; if (select !== 3'd0) begin bad++; $display("FAIL reset_select got=%0d exp=0", select); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL reset_load_n got=%0b exp=1", load_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (letter_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", letter_idx); end
    total++; if (sym_tick !== 1'b0) begin bad++; $display("FAIL reset_sym_tick got=%0b exp=0", sym_tick); end
    reset = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask
  task test_single();
    clear_rec();
    send(24'o2, 4'd1);
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL single_load_fall got=%0b exp=0", load_n); end
    total++; if (select !== 3'd2) begin bad++; $display("FAIL single_select got=%0d exp=2", select); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy); end
    step(); step();
    total++; if (sym_tick !== 1'b0) begin bad++; $display("FAIL single_tick_early got=%0b exp=0", sym_tick); end
    step();
    total++; if (sym_tick !== 1'b1) begin bad++; $display("FAIL single_tick got=%0b exp=1", sym_tick); end
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL single_load_hold got=%0b exp=0", load_n); end
    step();
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL single_load_rise got=%0b exp=1", load_n); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=0 exp=1"); end
    total++; if (dt - ft[0] !== 64) begin bad++; $display("FAIL single_done_lat got=%0d exp=64", dt - ft[0]); end
    total++; if (nfall !== 1) begin bad++; $display("FAIL single_nload got=%0d exp=1", nfall); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%0b exp=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%0b exp=0", done); end
    step();
  endtask
  task test_three();
    clear_rec();
    send(24'o705, 4'd3);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL three_timeout got=0 exp=1"); end
    total++; if (nfall !== 3) begin bad++; $display("FAIL three_nload got=%0d exp=3", nfall); end
    total++; if (ft[1] - ft[0] !== 64) begin bad++; $display("FAIL three_gap01 got=%0d exp=64", ft[1] - ft[0]); end
    total++; if (ft[2] - ft[1] !== 64) begin bad++; $display("FAIL three_gap12 got=%0d exp=64", ft[2] - ft[1]); end
    total++; if (fs[0] !== 3'd5) begin bad++; $display("FAIL three_sel0 got=%0d exp=5", fs[0]); end
    total++; if (fs[1] !== 3'd0) begin bad++; $display("FAIL three_sel1 got=%0d exp=0", fs[1]); end
    total++; if (fs[2] !== 3'd7) begin bad++; $display("FAIL three_sel2 got=%0d exp=7", fs[2]); end
    total++; if (fi[1] !== 3'd1) begin bad++; $display("FAIL three_idx1 got=%0d exp=1", fi[1]); end
    total++; if (fi[2] !== 3'd2) begin bad++; $display("FAIL three_idx2 got=%0d exp=2", fi[2]); end
    total++; if (dt - t0 !== 193) begin bad++; $display("FAIL three_done_lat got=%0d exp=193", dt - t0); end
    total++; if (select !== 3'd7) begin bad++; $display("FAIL three_select_hold got=%0d exp=7", select); end
    step(); step();
  endtask
  task test_empty();
    clear_rec();
    send(24'o7, 4'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done got=%0b exp=1", done); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL empty_load_n got=%0b exp=1", load_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy got=%0b exp=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL empty_done_pulse got=%0b exp=0", done); end
    for (int i = 0; i < 10; i++) step();
    total++; if (nfall !== 0) begin bad++; $display("FAIL empty_nload got=%0d exp=0", nfall); end
  endtask
  task test_clamp();
    clear_rec();
    send(24'o76543210, 4'd12);
    wait_done(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_timeout got=0 exp=1"); end
    total++; if (nfall !== 8) begin bad++; $display("FAIL clamp_nload got=%0d exp=8", nfall); end
    total++; if (dt - t0 !== 513) begin bad++; $display("FAIL clamp_done_lat got=%0d exp=513", dt - t0); end
    for (int i = 0; i < 8; i++) begin
      total++; if (fs[i] !== 3'(i)) begin bad++; $display("FAIL clamp_sel%0d got=%0d exp=%0d", i, fs[i], i); end
      total++; if (fi[i] !== 3'(i)) begin bad++; $display("FAIL clamp_idx%0d got=%0d exp=%0d", i, fi[i], i); end
    end
    step(); step();
  endtask
  task test_ignore_start();
    clear_rec();
    send(24'o321, 4'd3);
    for (int i = 0; i < 20; i++) step();
    start = 1'b1; msg = 24'o77777777; msg_len = 4'd8;
    step();
    start = 1'b0;
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL ignore_timeout got=0 exp=1"); end
    total++; if (nfall !== 3) begin bad++; $display("FAIL ignore_nload got=%0d exp=3", nfall); end
    total++; if (fs[0] !== 3'd1) begin bad++; $display("FAIL ignore_sel0 got=%0d exp=1", fs[0]); end
    total++; if (fs[1] !== 3'd2) begin bad++; $display("FAIL ignore_sel1 got=%0d exp=2", fs[1]); end
    total++; if (fs[2] !== 3'd3) begin bad++; $display("FAIL ignore_sel2 got=%0d exp=3", fs[2]); end
    total++; if (dt - t0 !== 193) begin bad++; $display("FAIL ignore_done_lat got=%0d exp=193", dt - t0); end
    step(); step();
  endtask
  task test_back_to_back();
    clear_rec();
    start = 1'b1; msg = 24'o2; msg_len = 4'd1; t0 = cyc;
    for (int i = 0; i < 300 && nfall < 2; i++) step();
    start = 1'b0;
    total++; if (nfall !== 2) begin bad++; $display("FAIL b2b_nload got=%0d exp=2", nfall); end
    total++; if (ft[0] - t0 !== 1) begin bad++; $display("FAIL b2b_first got=%0d exp=1", ft[0] - t0); end
    total++; if (dt - t0 !== 65) begin bad++; $display("FAIL b2b_done got=%0d exp=65", dt - t0); end
    total++; if (ft[1] - t0 !== 67) begin bad++; $display("FAIL b2b_second got=%0d exp=67", ft[1] - t0); end
    for (int i = 0; i < 200 && ndone < 2; i++) step();
    total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_ndone got=%0d exp=2", ndone); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%0b exp=0", busy); end
  endtask
  task test_async_reset();
    clear_rec();
    send(24'o64, 4'd2);
    for (int i = 0; i < 55; i++) step();
    #3 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    total++; if (select !== 3'd0) begin bad++; $display("FAIL areset_select got=%0d exp=0", select); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL areset_load_n got=%0b exp=1", load_n); end
    total++; if (sym_tick !== 1'b0) begin bad++; $display("FAIL areset_sym_tick got=%0b exp=0", sym_tick); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    total++; if (ndone !== 0) begin bad++; $display("FAIL areset_no_done got=%0d exp=0", ndone); end
    clear_rec();
    send(24'o35, 4'd2);
    total++; if (select !== 3'd5) begin bad++; $display("FAIL areset_restart_sel got=%0d exp=5", select); end
    total++; if (letter_idx !== 3'd0) begin bad++; $display("FAIL areset_restart_idx got=%0d exp=0", letter_idx); end
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_timeout got=0 exp=1"); end
    total++; if (nfall !== 2 || fs[1] !== 3'd3) begin bad++; $display("FAIL areset_restart got=%0d/%0d exp=2/3", nfall, fs[1]); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_three();
    test_empty();
    test_clamp();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
